// File: rtl/instr_encoder.sv
// ---------------------------------------------------------------------------
// instr_encoder
//   Program loader: turns symbolic instruction requests (add, sub, and, or,
//   slt, lw, sw, beq, j) into 32-bit MIPS words and writes them into the
//   instruction memory, one word per request, at auto-incrementing word
//   addresses. Runs before the pipeline leaves reset.
//
// Ports
//   clk, rst          clock; synchronous active-high reset
//   start             one-cycle pulse beginning a load (honoured in IDLE only)
//   base_addr, count  first word address / number of words, sampled on start
//   in_valid/in_ready request handshake
//   mnem, rs, rt, rd, imm, target   symbolic request fields
//   im_we, im_addr, im_wdata        IMEM write port
//   busy              high while accepting or writing
//   done              one-cycle pulse at the end of a load
//   err_illegal       sticky illegal-mnemonic flag, cleared by rst or start
// ---------------------------------------------------------------------------
module instr_encoder #(
    parameter int ADDR_W = 10
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    input  logic [ADDR_W-1:0] base_addr,
    input  logic [ADDR_W:0]   count,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [3:0]        mnem,
    input  logic [4:0]        rs,
    input  logic [4:0]        rt,
    input  logic [4:0]        rd,
    input  logic [15:0]       imm,
    input  logic [25:0]       target,
    output logic              im_we,
    output logic [ADDR_W-1:0] im_addr,
    output logic [31:0]       im_wdata,
    output logic              busy,
    output logic              done,
    output logic              err_illegal
);

    localparam logic [1:0] S_IDLE   = 2'd0;
    localparam logic [1:0] S_ACCEPT = 2'd1;
    localparam logic [1:0] S_WRITE  = 2'd2;
    localparam logic [1:0] S_DONE   = 2'd3;

    logic [1:0]        state_q, state_d;
    logic [ADDR_W-1:0] addr_q,  addr_d;   // next address to be written
    logic [ADDR_W:0]   rem_q,   rem_d;    // words still to load
    logic [ADDR_W-1:0] waddr_q, waddr_d;  // address presented on the write port
    logic [31:0]       wdata_q, wdata_d;  // word presented on the write port
    logic              err_q,   err_d;

    logic [31:0] enc_word;
    logic        enc_illegal;

    // Encoder: unused fields of a format are simply not referenced.
    always_comb begin
        enc_word    = 32'h0000_0000;
        enc_illegal = 1'b0;
        case (mnem)
            4'd0: enc_word = {6'h00, rs, rt, rd, 5'd0, 6'h20};
            4'd1: enc_word = {6'h00, rs, rt, rd, 5'd0, 6'h22};
            4'd2: enc_word = {6'h00, rs, rt, rd, 5'd0, 6'h24};
            4'd3: enc_word = {6'h00, rs, rt, rd, 5'd0, 6'h25};
            4'd4: enc_word = {6'h00, rs, rt, rd, 5'd0, 6'h2A};
            4'd5: enc_word = {6'h23, rs, rt, imm};
            4'd6: enc_word = {6'h2B, rs, rt, imm};
            4'd7: enc_word = {6'h04, rs, rt, imm};
            4'd8: enc_word = {6'h02, target};
            default: enc_illegal = 1'b1;  // a NOP is written instead
        endcase
    end

    always_comb begin
        state_d = state_q;
        addr_d  = addr_q;
        rem_d   = rem_q;
        waddr_d = waddr_q;
        wdata_d = wdata_q;
        err_d   = err_q;
        case (state_q)
            S_IDLE: begin
                if (start) begin
                    err_d = 1'b0;
                    if (count != '0) begin
                        addr_d  = base_addr;
                        rem_d   = count;
                        state_d = S_ACCEPT;
                    end else begin
                        state_d = S_DONE;
                    end
                end
            end
            S_ACCEPT: begin
                // Latch the word and its address together so the write port
                // holds steady between writes while addr_q moves on.
                if (in_valid) begin
                    wdata_d = enc_word;
                    waddr_d = addr_q;
                    if (enc_illegal) err_d = 1'b1;
                    state_d = S_WRITE;
                end
            end
            S_WRITE: begin
                addr_d  = addr_q + 1'b1;   // wraps modulo 2^ADDR_W
                rem_d   = rem_q - 1'b1;
                state_d = (rem_q == (ADDR_W+1)'(1)) ? S_DONE : S_ACCEPT;
            end
            default: state_d = S_IDLE;    // S_DONE
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= S_IDLE;
            addr_q  <= '0;
            rem_q   <= '0;
            waddr_q <= '0;
            wdata_q <= '0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            addr_q  <= addr_d;
            rem_q   <= rem_d;
            waddr_q <= waddr_d;
            wdata_q <= wdata_d;
            err_q   <= err_d;
        end
    end

    assign in_ready    = (state_q == S_ACCEPT);
    assign im_we       = (state_q == S_WRITE);
    assign busy        = (state_q == S_ACCEPT) || (state_q == S_WRITE);
    assign done        = (state_q == S_DONE);
    assign im_addr     = waddr_q;
    assign im_wdata    = wdata_q;
    assign err_illegal = err_q;

endmodule

// File: tb/tb_instr_encoder.sv
module tb_instr_encoder;
    localparam int AW = 10;

    logic          clk = 0;
    logic          rst, start, in_valid, in_ready;
    logic [AW-1:0] base_addr, im_addr;
    logic [AW:0]   count;
    logic [3:0]    mnem;
    logic [4:0]    rs, rt, rd;
    logic [15:0]   imm;
    logic [25:0]   target;
    logic          im_we, busy, done, err_illegal;
    logic [31:0]   im_wdata;

    int n_cmp = 0, n_bad = 0;
    bit ill;

    // request table consumed in order by each load
    int rq_m[64], rq_rs[64], rq_rt[64], rq_rd[64], rq_imm[64], rq_tg[64];

    instr_encoder #(.ADDR_W(AW)) dut (
        .clk(clk), .rst(rst), .start(start), .base_addr(base_addr), .count(count),
        .in_valid(in_valid), .in_ready(in_ready), .mnem(mnem), .rs(rs), .rt(rt), .rd(rd),
        .imm(imm), .target(target), .im_we(im_we), .im_addr(im_addr), .im_wdata(im_wdata),
        .busy(busy), .done(done), .err_illegal(err_illegal)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h at %0t", tag, got, exp, $time);
        end
    endtask

    // Reference encoding from the ISA field layout.
    function automatic logic [31:0] model(int m, int s, int t, int d, int i, int g);
        logic [31:0] r = 0;
        int fn[5] = '{32'h20, 32'h22, 32'h24, 32'h25, 32'h2A};
        if (m <= 4) r = (s << 21) | (t << 16) | (d << 11) | fn[m];
        else if (m == 5) r = (32'h23 << 26) | (s << 21) | (t << 16) | (i & 32'hFFFF);
        else if (m == 6) r = (32'h2B << 26) | (s << 21) | (t << 16) | (i & 32'hFFFF);
        else if (m == 7) r = (32'h04 << 26) | (s << 21) | (t << 16) | (i & 32'hFFFF);
        else if (m == 8) r = (32'h02 << 26) | (g & 32'h03FF_FFFF);
        return r;
    endfunction

    task automatic set_rq(int k, int m, int s, int t, int d, int i, int g);
        rq_m[k] = m; rq_rs[k] = s; rq_rt[k] = t; rq_rd[k] = d; rq_imm[k] = i; rq_tg[k] = g;
    endtask

    task automatic fill_rand(int n, bit allow_ill);
        for (int k = 0; k < n; k++)
            set_rq(k, allow_ill ? $urandom_range(0, 15) : $urandom_range(0, 8),
                   $urandom_range(0, 31), $urandom_range(0, 31), $urandom_range(0, 31),
                   $urandom_range(0, 65535), $urandom_range(0, 32'h03FF_FFFF));
    endtask

    // Runs one load from a negedge; checks every cycle until done.
    task automatic run_load(input int base, input int cnt, input int stall, input bit inj);
        int k = 0, cyc = 0;
        bit hs_prev = 0, seen = 0, v;
        logic [AW-1:0] ea = '0;
        logic [31:0]   ew = '0;
        start = 1; base_addr = AW'(base); count = (AW+1)'(cnt);
        @(negedge clk);
        start = 0; ill = 0;
        while (cyc < 400) begin
            if (hs_prev) begin
                chk("we", im_we, 1);
                chk("addr", im_addr, ea);
                chk("wdata", im_wdata, ew);
                chk("rdy_wr", in_ready, 0);
            end else begin
                chk("we_quiet", im_we, 0);
            end
            chk("err", err_illegal, ill);
            if (done) begin seen = 1; break; end
            chk("busy", busy, 1);
            if (!hs_prev) chk("rdy", in_ready, 1);
            hs_prev = 0;
            start = inj && cyc == 3;
            if (start) begin base_addr = ~base_addr; count = 1; end
            v = (k < cnt) && (cyc >= stall) && ($urandom_range(0, 3) != 0);
            in_valid = v;
            mnem = 4'(rq_m[k % 64]); rs = 5'(rq_rs[k % 64]); rt = 5'(rq_rt[k % 64]);
            rd = 5'(rq_rd[k % 64]); imm = 16'(rq_imm[k % 64]); target = 26'(rq_tg[k % 64]);
            if (v && in_ready) begin
                hs_prev = 1;
                ea = AW'((base + k) % (1 << AW));
                ew = model(rq_m[k], rq_rs[k], rq_rt[k], rq_rd[k], rq_imm[k], rq_tg[k]);
                if (rq_m[k] > 8) ill = 1;
                k++;
            end
            @(negedge clk);
            cyc++;
        end
        in_valid = 0; start = 0;
        chk("done_seen", 32'(seen), 1);
        chk("n_words", k, cnt);
        @(negedge clk);
        chk("done_pulse", done, 0);
        chk("idle_we", im_we, 0);
        chk("idle_busy", busy, 0);
    endtask

    initial begin
        rst = 1; start = 0; in_valid = 0; base_addr = 0; count = 0;
        mnem = 0; rs = 0; rt = 0; rd = 0; imm = 0; target = 0;
        repeat (3) @(negedge clk);
        chk("rst_we", im_we, 0); chk("rst_busy", busy, 0); chk("rst_done", done, 0);
        chk("rst_rdy", in_ready, 0); chk("rst_addr", im_addr, 0); chk("rst_wdata", im_wdata, 0);
        chk("rst_err", err_illegal, 0);
        rst = 0;
        @(negedge clk);

        // single ADD
        set_rq(0, 0, 1, 2, 3, 0, 0);
        run_load(0, 1, 0, 0);
        chk("add_lit", im_wdata, 32'h00221820);

        // LW/SW/BEQ/J from base 16
        set_rq(0, 5, 29, 8, 0, 4, 0);
        set_rq(1, 6, 0, 5, 0, 8, 0);
        set_rq(2, 7, 1, 2, 0, 16'hFFFF, 0);
        set_rq(3, 8, 0, 0, 0, 0, 26'h10);
        run_load(16, 4, 0, 0);
        chk("j_lit", im_wdata, 32'h08000010);
        chk("last_addr", im_addr, 19);

        // stall then random valid pattern
        fill_rand(8, 0);
        run_load($urandom_range(0, 1000), 8, 5, 0);

        // address wrap
        fill_rand(3, 0);
        run_load((1 << AW) - 2, 3, 0, 0);
        chk("wrap_addr", im_addr, 0);
        chk("wrap_err", err_illegal, 0);

        // illegal mid-load
        fill_rand(5, 0);
        rq_m[2] = 12;
        run_load(40, 5, 0, 0);
        chk("ill_sticky", err_illegal, 1);

        // next start clears error; stray start mid-load ignored
        fill_rand(6, 0);
        run_load(200, 6, 0, 1);

        // count == 0
        run_load(300, 0, 0, 0);

        // random loads
        for (int t = 0; t < 10; t++) begin
            fill_rand(16, ($urandom_range(0, 3) == 0));
            run_load($urandom_range(0, (1 << AW) - 1), $urandom_range(1, 12),
                     $urandom_range(0, 3), $urandom_range(0, 1));
        end

        // reset during a WRITE cycle
        set_rq(0, 1, 4, 5, 6, 0, 0);
        start = 1; base_addr = 100; count = 5;
        @(negedge clk);
        start = 0; in_valid = 1; mnem = 1; rs = 4; rt = 5; rd = 6;
        @(negedge clk);
        in_valid = 0;
        chk("pre_rst_we", im_we, 1);
        rst = 1;
        @(negedge clk);
        rst = 0;
        chk("rst_mid_we", im_we, 0); chk("rst_mid_busy", busy, 0);
        chk("rst_mid_done", done, 0); chk("rst_mid_addr", im_addr, 0);
        in_valid = 1;
        repeat (6) begin
            @(negedge clk);
            chk("post_rst_we", im_we, 0);
            chk("post_rst_done", done, 0);
            chk("post_rst_busy", busy, 0);
        end
        in_valid = 0;

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule

// File: doc/instr_encoder.md
Name: instr_encoder

Overview:
Inverse of the control/instruction decoder: turns symbolic instruction requests into 32-bit MIPS instruction words and writes them into instruction memory, one word per request. It covers the same subset the pipeline executes: add, sub, and, or, slt, lw, sw, beq, j. The bench/loader side feeds it over a valid/ready handshake; it drives the IMEM write port with an auto-incrementing word address. It is the program loader that runs before the pipeline comes out of reset.

Parameters:
ADDR_W, 10, IMEM word-address width; the address counter wraps modulo 2^ADDR_W.

Ports:
clk  in  1  clock, all state updates on posedge
rst  in  1  synchronous reset, active-high
start  in  1  one-cycle pulse that begins a load; ignored unless the FSM is in IDLE
base_addr  in  ADDR_W  first IMEM word address, sampled on start
count  in  ADDR_W+1  number of instructions to load, sampled on start
in_valid  in  1  request valid
in_ready  out  1  encoder can accept a request
mnem  in  4  0 ADD, 1 SUB, 2 AND, 3 OR, 4 SLT, 5 LW, 6 SW, 7 BEQ, 8 J; 9-15 illegal
rs, rt, rd  in  5 each  register fields
imm  in  16  immediate, passed raw, no extension
target  in  26  jump target field
im_we  out  1  IMEM write enable
im_addr  out  ADDR_W  IMEM word address
im_wdata  out  32  encoded instruction
busy  out  1  high in ACCEPT and WRITE
done  out  1  one-cycle pulse when a load completes
err_illegal  out  1  sticky; cleared by rst or an accepted start

Behaviour:
- Reset values: state IDLE; all outputs 0; address and remaining-count registers 0. A reset mid-load aborts the load: no further im_we and no done pulse.
- FSM states are IDLE, ACCEPT, WRITE and DONE.
- IDLE:
  - On start with count != 0: load addr <= base_addr, rem <= count, clear err_illegal, go to ACCEPT.
  - On start with count == 0: clear err_illegal, go to DONE.
- ACCEPT:
  - in_ready = 1.
  - A handshake (in_valid && in_ready) registers the encoded word and goes to WRITE.
  - in_valid low means wait, with no timeout.
- WRITE:
  - im_we = 1 for exactly one cycle, with im_addr = addr and im_wdata = the registered word.
  - in_ready = 0.
  - Next cycle: addr <= addr + 1 (wraps from 2^ADDR_W-1 to 0, no error), rem <= rem - 1.
  - If rem was 1, go to DONE; otherwise go to ACCEPT.
- DONE: done = 1 for one cycle, then IDLE.
- Throughput: 1 instruction per 2 cycles. If the handshake happens in cycle N, im_we is high in cycle N+1.
- start while busy or in DONE is ignored.
- im_addr and im_wdata hold their last value when im_we = 0.
- Encoding, with shamt always 0:
  - R-type: {6'h00, rs, rt, rd, 5'd0, funct}; funct ADD 6'h20, SUB 6'h22, AND 6'h24, OR 6'h25, SLT 6'h2A.
  - LW {6'h23, rs, rt, imm}; SW {6'h2B, rs, rt, imm}; BEQ {6'h04, rs, rt, imm}.
  - J {6'h02, target}.
  - Fields a format does not use are ignored.
- Illegal mnem (9-15):
  - The handshake still completes.
  - The word 32'h0000_0000 (NOP) is written and the address still advances.
  - err_illegal is set and stays set until rst or the next accepted start.

Test Plan:
- Reset then start, base_addr=0, count=1, ADD rs=1 rt=2 rd=3 -> one im_we at addr 0, wdata 32'h00221820; done pulses 1 cycle after the write.
- Load 4 words from base 16: LW rs=29 rt=8 imm=4; SW rs=0 rt=5 imm=8; BEQ rs=1 rt=2 imm=FFFF; J target=26'h10 -> writes at 16..19 of 8FA80004, AC050008, 1022FFFF, 08000010; every im_we exactly 1 cycle after its handshake.
- in_valid held low 5 cycles in ACCEPT, then a random valid/ready pattern over 8 words -> no writes while stalled, no dropped or duplicated words, addresses contiguous.
- base_addr=2^ADDR_W-2, count=3 -> writes at 2^ADDR_W-2, 2^ADDR_W-1, 0; err_illegal stays 0.
- mnem=12 mid-load -> that slot receives 0, err_illegal is 1 through done; the next start clears it. start with count=0 -> done 1 cycle later, no im_we.
- Assert rst during a WRITE cycle -> from the next cycle: im_we=0, busy=0, done never pulses; start pulsed during an active load is ignored.
